// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported 64-bit memory between instruction
// fetch (10-byte unaligned window built from 2 or 3 aligned word reads) and
// data access (aligned 8-byte read/write), with range checking and a
// per-state ack timeout.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | arbitrate pending requests, range-check the winner
// IF0   | fetch: read aligned word containing if_addr into w0
// IF1   | fetch: read next word into w1
// IF2   | fetch: read third word (only when if_addr[2:0]==7)
// DM    | data: single aligned read or write
// RSP   | ready pulse on the owning port, then back to IDLE
module mem_arbiter #(
    parameter logic [63:0] MEM_BYTES = 64'h400,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ready,
    output logic [79:0] if_data,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_ready,
    output logic [63:0] dm_rdata,
    output logic        dm_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, IF0, IF1, IF2, DM, RSP} state_t;

    // Down-counter holds the remaining no-ack cycles; it only needs TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(TIMEOUT - 1);

    state_t        state;
    logic          starved;
    logic [CW-1:0] wait_cnt;
    logic [63:0]   w0;
    logic [63:0]   w1;

    logic [64:0]   if_end;
    logic [64:0]   dm_end;
    logic          if_bad;
    logic          dm_bad;
    logic          pick_dm;
    logic          pick_if;
    logic [2:0]    lane;
    logic          expired;

    // Range checks are done in 65 bits so an address near 2^64 cannot wrap.
    assign if_end  = {1'b0, if_addr} + 65'd10;
    assign dm_end  = {1'b0, dm_addr} + 65'd8;
    assign if_bad  = if_end > {1'b0, MEM_BYTES};
    assign dm_bad  = (dm_addr[2:0] != 3'd0) || (dm_end > {1'b0, MEM_BYTES});
    assign pick_dm = dm_req && (!if_req || !starved);
    assign pick_if = if_req && !pick_dm;
    assign lane    = if_addr[2:0];
    assign expired = (wait_cnt == '0) && !mem_ack;

    // Extract the 10-byte window starting at byte offset off of three words.
    function automatic logic [79:0] window(input logic [191:0] words, input logic [2:0] off);
        logic [191:0] sh;
        sh = words >> {off, 3'b000};
        return sh[79:0];
    endfunction

    // Sequencer: arbitration, memory strobing, timeout and registered responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            starved   <= 1'b0;
            wait_cnt  <= '0;
            w0        <= '0;
            w1        <= '0;
            if_ready  <= 1'b0;
            if_data   <= '0;
            if_err    <= 1'b0;
            dm_ready  <= 1'b0;
            dm_rdata  <= '0;
            dm_err    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= WAIT_LOAD;
                    if (pick_dm) begin
                        if (if_req) starved <= 1'b1;
                        if (dm_bad) begin
                            state    <= RSP;
                            dm_ready <= 1'b1;
                            dm_err   <= 1'b1;
                            dm_rdata <= '0;
                        end else begin
                            state     <= DM;
                            mem_req   <= 1'b1;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end
                    end else if (pick_if) begin
                        starved <= 1'b0;
                        if (if_bad) begin
                            state    <= RSP;
                            if_ready <= 1'b1;
                            if_err   <= 1'b1;
                            if_data  <= '0;
                        end else begin
                            state    <= IF0;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= {if_addr[63:3], 3'b000};
                        end
                    end
                end
                IF0, IF1, IF2: begin
                    if (mem_ack) begin
                        wait_cnt <= WAIT_LOAD;
                        if (state == IF0) begin
                            w0       <= mem_rdata;
                            mem_addr <= mem_addr + 64'd8;
                            state    <= IF1;
                        end else if (state == IF1 && lane == 3'd7) begin
                            w1       <= mem_rdata;
                            mem_addr <= mem_addr + 64'd8;
                            state    <= IF2;
                        end else begin
                            mem_req  <= 1'b0;
                            state    <= RSP;
                            if_ready <= 1'b1;
                            if_err   <= 1'b0;
                            if (state == IF1)
                                if_data <= window({64'd0, mem_rdata, w0}, lane);
                            else
                                if_data <= window({mem_rdata, w1, w0}, lane);
                        end
                    end else if (expired) begin
                        mem_req  <= 1'b0;
                        state    <= RSP;
                        if_ready <= 1'b1;
                        if_err   <= 1'b1;
                        if_data  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                DM: begin
                    if (mem_ack || expired) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        state    <= RSP;
                        dm_ready <= 1'b1;
                        dm_err   <= !mem_ack;
                        dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : 64'd0;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                RSP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against a behavioural word memory;
// expected responses are queued at issue time and checked by a monitor.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ready;
    logic [79:0] if_data;
    logic        if_err;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [63:0] dm_addr = '0;
    logic [63:0] dm_wdata = '0;
    logic        dm_ready;
    logic [63:0] dm_rdata;
    logic        dm_err;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_data(if_data), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] data;
        logic        err;
        int          start;
        int          lat;
    } exp_t;

    exp_t exp_if[$];
    exp_t exp_dm[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic miss(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: event absent or unexpected (cycle %0d)", nm, cyc);
    endtask

    // Behavioural memory: byte at address a holds (a-16)&0xFF.
    logic [63:0] mem_words [0:127];
    int          wait_states = 0;
    bit          block_ack = 0;
    int          ws_cnt = 0;
    int          req_cycles = 0;
    logic [63:0] acc_addr[$];
    logic        acc_we[$];
    logic [6:0]  idx;

    initial begin
        for (int w = 0; w < 128; w++)
            for (int b = 0; b < 8; b++)
                mem_words[w][8*b +: 8] = 8'(w*8 + b - 16);
    end

    always @(negedge clk) begin
        if (mem_req) req_cycles++;
        if (mem_req && !block_ack && ws_cnt >= wait_states) begin
            mem_ack = 1'b1;
            idx = mem_addr[9:3];
            if (mem_we) begin
                mem_words[idx] = mem_wdata;
                mem_rdata = '0;
            end else begin
                mem_rdata = mem_words[idx];
            end
            acc_addr.push_back(mem_addr);
            acc_we.push_back(mem_we);
            ws_cnt = 0;
        end else begin
            mem_ack = 1'b0;
            ws_cnt = mem_req ? ws_cnt + 1 : 0;
        end
    end

    // Monitor: every ready pulse is matched against the head of its queue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (if_ready && dm_ready) miss("two_readies");
        if (if_ready) begin
            if (exp_if.size() == 0) miss("if_spurious_ready");
            else begin
                e = exp_if.pop_front();
                chk("if_data", if_data, e.data);
                chk("if_err", {79'd0, if_err}, {79'd0, e.err});
                if (e.lat >= 0) chk("if_latency", 80'(cyc - e.start), 80'(e.lat));
            end
        end
        if (dm_ready) begin
            if (exp_dm.size() == 0) miss("dm_spurious_ready");
            else begin
                e = exp_dm.pop_front();
                chk("dm_rdata", {16'd0, dm_rdata}, e.data);
                chk("dm_err", {79'd0, dm_err}, {79'd0, e.err});
                if (e.lat >= 0) chk("dm_latency", 80'(cyc - e.start), 80'(e.lat));
            end
        end
    end

    task automatic clr_log();
        acc_addr.delete();
        acc_we.delete();
        req_cycles = 0;
    endtask

    task automatic start_if(input logic [63:0] a, input logic [79:0] d, input logic e, input int lat);
        exp_t x;
        x.data = d; x.err = e; x.start = cyc; x.lat = lat;
        exp_if.push_back(x);
        if_addr = a;
        if_req = 1'b1;
    endtask

    task automatic start_dm(input logic we, input logic [63:0] a, input logic [63:0] wd,
                            input logic [63:0] d, input logic e, input int lat);
        exp_t x;
        x.data = {16'd0, d}; x.err = e; x.start = cyc; x.lat = lat;
        exp_dm.push_back(x);
        dm_we = we; dm_addr = a; dm_wdata = wd;
        dm_req = 1'b1;
    endtask

    // Wait (bounded) for the port's ready, then drop req on the following edge.
    task automatic wait_if(input string nm);
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (if_ready) seen = 1;
        end
        if (!seen) miss(nm);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic wait_dm(input string nm);
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (dm_ready) seen = 1;
        end
        if (!seen) miss(nm);
        @(posedge clk); #1;
        dm_req = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a, input logic [79:0] d, input logic e, input int lat);
        clr_log();
        start_if(a, d, e, lat);
        wait_if("if_ready_timeout");
    endtask

    task automatic data(input logic we, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] d, input logic e, input int lat);
        clr_log();
        start_dm(we, a, wd, d, e, lat);
        wait_dm("dm_ready_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_flags", {74'd0, if_ready, if_err, dm_ready, dm_err, mem_req, mem_we}, 80'd0);
        chk("rst_if_data", if_data, 80'd0);
        chk("rst_dm_rdata", {16'd0, dm_rdata}, 80'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 80'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 80'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        fetch(64'h10, 80'h09080706050403020100, 1'b0, 3);
        chk("f10_acc_count", 80'(acc_addr.size()), 80'd2);
        chk("f10_req_cycles", 80'(req_cycles), 80'd2);
        if (acc_addr.size() == 2) begin
            chk("f10_addr0", {16'd0, acc_addr[0]}, 80'h10);
            chk("f10_addr1", {16'd0, acc_addr[1]}, 80'h18);
        end

        fetch(64'h17, 80'h100F0E0D0C0B0A090807, 1'b0, 4);
        chk("f17_acc_count", 80'(acc_addr.size()), 80'd3);
        if (acc_addr.size() == 3)
            chk("f17_addr2", {16'd0, acc_addr[2]}, 80'h20);

        fetch(64'h13, 80'h0C0B0A09080706050403, 1'b0, 3);
        fetch(64'h3F6, 80'hEFEEEDECEBEAE9E8E7E6, 1'b0, 3);

        fetch(64'h3FA, 80'd0, 1'b1, 1);
        chk("f3fa_req_cycles", 80'(req_cycles), 80'd0);

        data(1'b0, 64'h43, 64'd0, 64'd0, 1'b1, 1);
        chk("d43_req_cycles", 80'(req_cycles), 80'd0);

        data(1'b0, 64'h3F8, 64'd0, 64'hEFEEEDECEBEAE9E8, 1'b0, 2);
        data(1'b0, 64'h400, 64'd0, 64'd0, 1'b1, 1);

        // Contention: data wins first, then fetch wins over the new data read.
        clr_log();
        start_if(64'h20, 80'h19181716151413121110, 1'b0, 6);
        start_dm(1'b1, 64'h40, 64'h00000000DEADBEEF, 64'd0, 1'b0, 2);
        wait_dm("dm_write_timeout");
        start_dm(1'b0, 64'h40, 64'd0, 64'h00000000DEADBEEF, 1'b0, 6);
        wait_if("if_contend_timeout");
        wait_dm("dm_readback_timeout");
        chk("contend_acc_count", 80'(acc_addr.size()), 80'd4);
        if (acc_addr.size() == 4) begin
            chk("contend_first_addr", {16'd0, acc_addr[0]}, 80'h40);
            chk("contend_first_we", {79'd0, acc_we[0]}, 80'd1);
            chk("contend_second_addr", {16'd0, acc_addr[1]}, 80'h20);
            chk("contend_last_we", {79'd0, acc_we[3]}, 80'd0);
        end

        block_ack = 1;
        data(1'b0, 64'h40, 64'd0, 64'd0, 1'b1, 17);
        chk("timeout_req_cycles", 80'(req_cycles), 80'd16);
        block_ack = 0;

        // Reset while fetch 0x17 with 3 wait states sits in IF1.
        wait_states = 3;
        clr_log();
        start_if(64'h17, 80'd0, 1'b0, -1);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        if_req = 1'b0;
        exp_if.delete();
        #1;
        chk("rst_mid_mem_req", {79'd0, mem_req}, 80'd0);
        chk("rst_mid_acc_count", 80'(acc_addr.size()), 80'd1);
        repeat (2) @(negedge clk);
        chk("rst_mid_if_ready", {79'd0, if_ready}, 80'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        fetch(64'h17, 80'h100F0E0D0C0B0A090807, 1'b0, 13);
        chk("refetch_acc_count", 80'(acc_addr.size()), 80'd3);
        wait_states = 0;

        repeat (3) @(posedge clk);
        chk("if_queue_empty", 80'(exp_if.size()), 80'd0);
        chk("dm_queue_empty", 80'(exp_dm.size()), 80'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter that shares the single-ported 64-bit data memory between the Y86-64 pipeline's instruction fetch port and its data access port. It assembles the 10-byte unaligned instruction window from 2 or 3 aligned word reads and performs aligned 8-byte data reads and writes. It range-checks every access and reports address errors so fetch can raise STATE_ADR via imem_error and memory via dmem_error. A `ready` pulse tells the pipeline control when to release its stall.

## Interface
Parameters:
- MEM_BYTES, 64'h400: memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.
- TIMEOUT, 16: cycles `mem_req` may stay high without `mem_ack` before the access is aborted with an error.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  64  fetch byte address (any alignment), stable while if_req
- if_ready  out  1  one-cycle pulse: if_data/if_err valid
- if_data  out  80  instruction bytes if_addr..if_addr+9, little-endian (byte at if_addr in [7:0])
- if_err  out  1  fetch address error (valid with if_ready)
- dm_req  in  1  data request, held until dm_ready
- dm_we  in  1  1 = write, 0 = read; stable while dm_req
- dm_addr  in  64  data byte address, stable while dm_req
- dm_wdata  in  64  write data
- dm_ready  out  1  one-cycle pulse: dm_rdata/dm_err valid
- dm_rdata  out  64  read data (0 for writes and errors)
- dm_err  out  1  data address error (valid with dm_ready)
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  64  word address, bits [2:0] always 0
- mem_wdata  out  64  memory write data
- mem_ack  in  1  memory completes access this cycle; mem_rdata valid
- mem_rdata  in  64  memory read word

## Operation
- States: IDLE, IF0, IF1, IF2, DM, RSP.
- IDLE: evaluate requests.
  - If both requests are pending, dm wins unless the `starved` flag is set; then if wins.
  - `starved` is set when dm is granted while if_req=1.
  - `starved` is cleared when if is granted.
- Range checks (65-bit arithmetic, no wrap):
  - Fetch error: if_addr+10 > MEM_BYTES.
  - Data error: dm_addr[2:0]!=0 or dm_addr+8 > MEM_BYTES.
  - An erroring request goes IDLE->RSP with err=1 and no memory access.
- Fetch sequence:
  - IF0 reads word (if_addr & ~7) into w0.
  - IF1 reads word +8 into w1.
  - If if_addr[2:0]==7, IF2 reads word +16 into w2; otherwise go to RSP.
  - if_data = ({w2,w1,w0} >> 8*if_addr[2:0])[79:0], with w2=0 when unused.
- Data sequence: DM issues one access with mem_addr=dm_addr, mem_we=dm_we, mem_wdata=dm_wdata. On a read, mem_rdata is captured.
- Memory strobe and advance:
  - mem_req=1 exactly in IF0/IF1/IF2/DM.
  - The state advances only on an edge with mem_ack=1.
  - mem_we=0 in all fetch states.
- Timeout: a wait counter counts cycles in the current memory state without ack. When it reaches TIMEOUT, abort to RSP with err=1 for the owning port; for a fetch, if_data=0.
- RSP: pulse the owning port's ready for one cycle with data/err, then return to IDLE.
- The requester drops req on the edge where it samples ready, so IDLE sees fresh requests.

## Timing
- Reset (async, immediate): state=IDLE; starved=0; counters 0. All outputs 0: if_ready, if_data, if_err, dm_ready, dm_rdata, dm_err, mem_req, mem_we, mem_addr, mem_wdata.
- Reset mid-access drops mem_req at once. No ready is produced for the aborted request.
- Zero-wait memory (mem_ack=1 whenever mem_req=1), with the request first seen in IDLE at cycle 0:
  - Fetch, offset 0..6: ready in cycle 3.
  - Fetch, offset 7: ready in cycle 4.
  - Data access: ready in cycle 2.
  - Address error: ready in cycle 1.
- Each mem_ack wait cycle adds one cycle of latency.
- A grant is never preempted; a later dm_req waits for the fetch sequence to finish.
- At most one ready pulse per cycle. Outputs are registered; data outputs hold their value until the next ready for that port.
- Back-to-back: a new request in the IDLE cycle after RSP is granted in that cycle; minimum gap between two readies is 2 cycles.

## Test plan
- Fetch if_addr=0x10, memory words 0x10=0x0706050403020100, 0x18=0x0F0E0D0C0B0A0908, zero-wait -> if_ready in cycle 3, if_data=80'h09080706050403020100, if_err=0, two mem_req cycles at 0x10, 0x18.
- Fetch if_addr=0x17 -> three reads 0x10, 0x18, 0x20; if_ready in cycle 4; if_data[7:0]=0x07 (byte 0x17), if_data[79:72]=byte 0x20.
- if_req and dm_req (write 0xDEADBEEF to 0x40) asserted together, then both repeated -> dm served first with mem_we=1 at 0x40; the next arbitration with both pending goes to fetch; a later read of 0x40 returns 0xDEADBEEF.
- dm_addr=0x43, and separately if_addr=0x3FA with MEM_BYTES=0x400 -> err=1, ready in cycle 1, mem_req never asserted.
- mem_ack held 0 during a data read -> mem_req high for exactly 16 cycles, then dm_ready with dm_err=1, dm_rdata=0.
- rst pulsed during IF1 with 3 wait states -> mem_req falls asynchronously, no if_ready; after release, the repeated fetch completes normally.
